// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor: diff = A - B - bin (mod 2^WIDTH), one bit
// per clock, LSB first, on a single full-subtractor cell. A start/done
// handshake frames each operation; a new operation can be accepted in the
// DONE cycle so back-to-back requests run with no bubble.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request; sampled only in IDLE or DONE
//   A        in   [WIDTH] minuend, captured on accept
//   B        in   [WIDTH] subtrahend, captured on accept
//   bin      in   borrow-in, captured on accept
//   busy     out  high while bits are being processed
//   done     out  one-cycle pulse, results valid
//   diff     out  [WIDTH] result (partial shift while busy)
//   bout     out  unsigned borrow-out of bit WIDTH-1
//   ovf      out  signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             r_ovf;

    logic w_accept;
    logic w_last;
    logic w_a;
    logic w_b;
    logic w_d;
    logic w_bo;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign w_a    = r_a_sh[0];
    assign w_b    = r_b_sh[0];
    assign w_d    = w_a ^ w_b ^ r_borrow;
    assign w_bo   = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    assign w_last = (r_cnt == LAST_BIT);

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Accepting here gives back-to-back operation with no bubble.
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_BUSY;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, borrow flop, bit counter, result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // Results are deliberately left alone so they hold until the
            // next operation completes.
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_diff   <= {w_d, r_diff[WIDTH-1:1]};
            r_borrow <= w_bo;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                // On the sign bit: overflow when operand signs differ and the
                // result sign differs from the minuend's.
                r_bout <= w_bo;
                r_ovf  <= (w_a ^ w_b) & (w_a ^ w_d);
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH=4). Directed vectors with
// hand-computed results are pushed into a scoreboard queue as they are issued;
// a monitor pops and compares each time done pulses.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic         start   = 1'b0;
    logic [W-1:0] A       = '0;
    logic [W-1:0] B       = '0;
    logic         bin     = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];

    int n_pass        = 0;
    int n_total       = 0;
    int cyc           = 0;
    int n_done        = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    int busy_cnt      = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("bout", 32'(bout), 32'(e.bout));
                check("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
    end

    // Wait (bounded) until the monitor has seen a done beyond count n0.
    task automatic wait_done(input int n0, input string name);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (n_done != n0) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input logic [W-1:0] ed, input logic ebo, input logic eovf);
        int n0;
        int acc;
        @(negedge clk);
        A = a; B = b; bin = bi; start = 1'b1;
        busy_cnt = 0;
        n0 = n_done;
        sb_q.push_back(exp_t'{diff: ed, bout: ebo, ovf: eovf});
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
        check("busy_after_accept", 32'(busy), 32'd1);
        // Operands may change freely once captured.
        A = ~a; B = ~b; bin = ~bi;
        wait_done(n0, "op_timeout");
        check("done_latency", 32'(last_done_cyc - acc), 32'(W));
        check("busy_cycles", 32'(busy_cnt), 32'(W));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n0;

        // Reset state.
        #2 reset_n = 1'b0;
        #1 check("reset_outputs", 32'({busy, done, diff, bout, ovf}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Single operations: A, B, bin -> diff, bout, ovf.
        run_op(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0); //  7 - 3
        run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0); //  3 - 5
        run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0); //  0 - 0 - 1
        run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1); // -8 - 1
        run_op(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1); //  7 - (-1)
        run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0); // -1 - (-1) - 1
        run_op(4'b1000, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b1); // -8 - 0 - 1

        // Back-to-back: start held high, 7-3 then 9-9 accepted in DONE.
        @(negedge clk);
        A = 4'd7; B = 4'd3; bin = 1'b0; start = 1'b1;
        n0 = n_done;
        sb_q.push_back(exp_t'{diff: 4'b0100, bout: 1'b0, ovf: 1'b0});
        @(negedge clk);
        A = 4'd9; B = 4'd9;
        sb_q.push_back(exp_t'{diff: 4'b0000, bout: 1'b0, ovf: 1'b0});
        wait_done(n0, "b2b_first_timeout");
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_no_bubble", 32'(busy), 32'd1);
        wait_done(n0 + 1, "b2b_second_timeout");
        check("b2b_done_spacing", 32'(last_done_cyc - prev_done_cyc), 32'(W + 1));

        // Abort: 7-3 started, stray start while busy, then reset mid-BUSY.
        // Nothing is pushed, so any done pulse is flagged by the monitor.
        @(negedge clk);
        A = 4'd7; B = 4'd3; bin = 1'b0; start = 1'b1;
        n0 = n_done;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignores_start", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1 check("abort_reset_outputs", 32'({busy, done, diff, bout, ovf}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        check("no_done_after_abort", 32'(n_done), 32'(n0));
        check("idle_after_abort", 32'({busy, done, diff, bout, ovf}), 32'd0);

        // Fresh operation after the abort.
        run_op(4'd5, 4'd2, 1'b0, 4'b0011, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = A - B - bin, one bit per clock, LSB first.
- Produces diff, borrow-out and signed overflow.
- Companion to the team's parallel ripple-carry adder: the subtract direction, time-multiplexed onto one full-subtractor cell.
- Used by lab datapaths that need area-cheap subtraction under a start/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while not busy.
- A  input  WIDTH  minuend; captured when start is accepted.
- B  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results valid.
- diff  output  WIDTH  result, A - B - bin mod 2^WIDTH.
- bout  output  1  unsigned borrow-out (1 when A < B + bin).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE immediately.
  - busy=0, done=0, diff=0, bout=0, ovf=0.
  - Operand registers and bit counter are cleared.
  - Deassertion takes effect at the next clk edge.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start=1 at an edge, capture A, B and bin into shift registers and the borrow flop, clear the counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each edge processes bit i = counter. With a=A_sh[0], b=B_sh[0], br=borrow flop:
    - d = a^b^br
    - bo = (~a&b) | (~(a^b)&br)
  - d shifts into the diff register MSB; the register shifts right. Operands shift right. The borrow flop takes bo. The counter increments.
  - At the edge processing bit WIDTH-1, latch bout=bo and ovf=(a^b)&(a^d), using MSB operands, then go to DONE.
  - start is ignored while in BUSY.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 at that edge, capture new operands and go to BUSY (back-to-back operation with no bubble). Otherwise go to IDLE.
- busy=1 in BUSY only.
- Latency: start accepted at edge t0. Bits are processed at edges t1..tWIDTH. done is high during the cycle after edge tWIDTH (exactly WIDTH cycles after acceptance).
- Throughput: one operation per WIDTH+1 cycles.
- diff, bout and ovf hold their value from DONE until the next operation completes; they are not cleared by start.
- diff is not valid mid-operation; it holds a partial shift and the bench must not check it then.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - bout is the borrow out of bit WIDTH-1.
  - ovf uses operands interpreted as signed WIDTH-bit values.
- Reset mid-BUSY aborts the operation: no done pulse, outputs return to reset values.
- A and B may change freely after acceptance with no effect.

Test Plan:
- Reset, then A=0111, B=0011, bin=0, start pulse -> busy high for 4 cycles; done pulse 4 cycles after accept; diff=0100, bout=0, ovf=0.
- A=0011, B=0101, bin=0 -> diff=1110, bout=1, ovf=0.
- A=0000, B=0000, bin=1 -> diff=1111, bout=1, ovf=0.
- A=1000, B=0001, bin=0 (-8 - 1) -> diff=0111, bout=0, ovf=1.
- Start held high continuously with operands 7-3 then 9-9 -> second op accepted in the DONE cycle; done pulses 5 cycles apart; diff=0100 then 0000.
- Start 7-3, pulse start again while busy, then assert reset_n=0 mid-BUSY -> second start ignored; after reset all outputs 0 with no done. A fresh 5-2 then gives diff=0011.
